// File: rtl/ref_cmp_sched_if.sv
// Handshake/data bundle between ref_cmp_sched and its neighbours.
// Latency: n/a (wires only).
// Backpressure: i_Valid/o_Read pop handshake on the source side, i_Ready gates the compare stream.
// slave  : scheduler side (config + vec_cat input, slot/compare outputs, status).
// master : environment side (drives i_* signals, observes o_* signals).
interface ref_cmp_sched_if #(
  parameter int BUS_WIDTH    = 96,
  parameter int VEC_ID_WIDTH = 8,
  parameter int REF_VEC_NO   = 8
);
  logic [VEC_ID_WIDTH-1:0] i_CmpVectorNo;
  logic                    i_CmpVectorNoValid;
  logic                    o_CmpVectorNoWack;
  logic [BUS_WIDTH-1:0]    i_Vector;
  logic                    i_Valid;
  logic                    o_Read;
  logic                    i_Ready;
  logic [BUS_WIDTH-1:0]    o_Vector;
  logic [VEC_ID_WIDTH-1:0] o_VecID;
  logic [REF_VEC_NO-1:0]   o_RefLoad;
  logic                    o_CmpValid;
  logic                    o_CmpLast;
  logic                    o_Busy;
  logic                    o_Done;
  logic [15:0]             o_RoundCnt;

  modport slave (
    input  i_CmpVectorNo, i_CmpVectorNoValid, i_Vector, i_Valid, i_Ready,
    output o_CmpVectorNoWack, o_Read, o_Vector, o_VecID, o_RefLoad,
           o_CmpValid, o_CmpLast, o_Busy, o_Done, o_RoundCnt
  );

  modport master (
    output i_CmpVectorNo, i_CmpVectorNoValid, i_Vector, i_Valid, i_Ready,
    input  o_CmpVectorNoWack, o_Read, o_Vector, o_VecID, o_RefLoad,
           o_CmpValid, o_CmpLast, o_Busy, o_Done, o_RoundCnt
  );
endinterface

// File: rtl/ref_cmp_sched.sv
// Round scheduler: loads REF_VEC_NO reference words into slots, then streams N compare words.
// Latency: one cycle from a pop (o_Read) to the matching o_RefLoad / o_CmpValid strobe.
// Backpressure: i_Valid low stalls loading; i_Valid or i_Ready low stalls streaming, position kept.
// Ports: clk, rst (async active-high); bus (ref_cmp_sched_if.slave) carries config write/ack,
//   source pop interface, registered slot/compare outputs and Busy/Done/RoundCnt status.
// Build option: define SCHED_ROUND_CNT_EN to include the 16-bit completed-round counter,
//   otherwise o_RoundCnt is tied to 0.
module ref_cmp_sched #(
  parameter int BUS_WIDTH    = 96,
  parameter int VEC_ID_WIDTH = 8,
  parameter int REF_VEC_NO   = 8
) (
  input  logic              clk,
  input  logic              rst,
  ref_cmp_sched_if.slave    bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_REF   = 2'd1;
  localparam logic [1:0] STREAM_CMP = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  localparam logic [VEC_ID_WIDTH-1:0] REF_LAST = VEC_ID_WIDTH'(REF_VEC_NO - 1);

  logic [1:0]              state_q, state_d;
  logic [VEC_ID_WIDTH-1:0] cnt_q, cnt_d;
  logic [VEC_ID_WIDTH-1:0] idx_q, idx_d;
  logic [BUS_WIDTH-1:0]    vec_q, vec_d;
  logic [VEC_ID_WIDTH-1:0] vec_id_q, vec_id_d;
  logic [REF_VEC_NO-1:0]   ref_load_q, ref_load_d;
  logic                    cmp_valid_q, cmp_valid_d;
  logic                    cmp_last_q, cmp_last_d;
  logic                    wack_q, wack_d;
  logic                    read;

  // Pop is purely combinational so the source FIFO advances in the same cycle.
  always_comb begin
    read = 1'b0;
    if (state_q == LOAD_REF)   read = bus.i_Valid;
    if (state_q == STREAM_CMP) read = bus.i_Valid & bus.i_Ready;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    vec_id_d    = vec_id_q;
    ref_load_d  = '0;
    cmp_valid_d = 1'b0;
    cmp_last_d  = 1'b0;
    wack_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_CmpVectorNoValid) begin
          cnt_d  = bus.i_CmpVectorNo;
          wack_d = 1'b1;
          idx_d  = '0;
          // A zero count is acknowledged but starts no round.
          if (bus.i_CmpVectorNo != '0) state_d = LOAD_REF;
        end
      end
      LOAD_REF: begin
        if (read) begin
          vec_d      = bus.i_Vector;
          vec_id_d   = idx_q;
          ref_load_d = {{(REF_VEC_NO-1){1'b0}}, 1'b1} << idx_q;
          if (idx_q == REF_LAST) begin
            idx_d   = '0;
            state_d = STREAM_CMP;
          end else begin
            idx_d = idx_q + VEC_ID_WIDTH'(1);
          end
        end
      end
      STREAM_CMP: begin
        if (read) begin
          vec_d       = bus.i_Vector;
          vec_id_d    = idx_q;
          cmp_valid_d = 1'b1;
          // Compare against N-1 so N = 2^VEC_ID_WIDTH-1 never needs the index to wrap.
          if (idx_q == cnt_q - VEC_ID_WIDTH'(1)) begin
            cmp_last_d = 1'b1;
            idx_d      = '0;
            state_d    = DONE;
          end else begin
            idx_d = idx_q + VEC_ID_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      vec_q       <= '0;
      vec_id_q    <= '0;
      ref_load_q  <= '0;
      cmp_valid_q <= 1'b0;
      cmp_last_q  <= 1'b0;
      wack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      vec_id_q    <= vec_id_d;
      ref_load_q  <= ref_load_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_last_q  <= cmp_last_d;
      wack_q      <= wack_d;
    end
  end

`ifdef SCHED_ROUND_CNT_EN
  logic [15:0] round_cnt_q, round_cnt_d;

  // Wraps 0xFFFF -> 0 naturally.
  always_comb begin
    round_cnt_d = round_cnt_q;
    if (state_q == DONE) round_cnt_d = round_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) round_cnt_q <= '0;
    else     round_cnt_q <= round_cnt_d;
  end

  assign bus.o_RoundCnt = round_cnt_q;
`else
  assign bus.o_RoundCnt = '0;
`endif

  assign bus.o_Read            = read;
  assign bus.o_CmpVectorNoWack = wack_q;
  assign bus.o_Vector          = vec_q;
  assign bus.o_VecID           = vec_id_q;
  assign bus.o_RefLoad         = ref_load_q;
  assign bus.o_CmpValid        = cmp_valid_q;
  assign bus.o_CmpLast         = cmp_last_q;
  assign bus.o_Busy            = (state_q == LOAD_REF) || (state_q == STREAM_CMP);
  assign bus.o_Done            = (state_q == DONE);

endmodule

// File: tb/tb_ref_cmp_sched.sv
// Scoreboard bench for ref_cmp_sched: stimulus pushes expected slot/compare events,
// a negedge monitor pops and compares whenever a strobe appears.
// Backpressure exercised via i_Ready toggling and periodic i_Valid gaps.
module tb_ref_cmp_sched;
  localparam int BW = 96;
  localparam int IW = 8;
  localparam int RN = 8;

  typedef struct {
    bit              is_cmp;
    logic [BW-1:0]   vec;
    int              id;
    bit              last;
  } exp_t;

  logic clk;
  logic rst;

  ref_cmp_sched_if #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(IW), .REF_VEC_NO(RN)) bus();

  ref_cmp_sched #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(IW), .REF_VEC_NO(RN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [BW-1:0] src_q[$];
  exp_t          exp_q[$];
  bit            pop_pending = 0;
  bit            toggle_mode = 0;
  bit            gap_mode    = 0;
  int            gap_ctr     = 0;
  int            done_cnt    = 0;
  int            wack_cnt    = 0;
  int            ref_seen    = 0;
  int            cmp_seen    = 0;
  int            exp_rounds  = 0;
  int            exp_wacks   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_word(input int tag, input int i);
    logic [31:0] iv;
    logic [31:0] tv;
    iv = i;
    tv = tag;
    return {16'hC0DE, tv[15:0], iv, ~iv};
  endfunction

  // Queue the words of one round and the events they must produce.
  task automatic load_round(input int n, input int tag);
    exp_t e;
    for (int i = 0; i < RN; i++) begin
      src_q.push_back(mk_word(tag, i));
      e.is_cmp = 0; e.vec = mk_word(tag, i); e.id = i; e.last = 0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      src_q.push_back(mk_word(tag, 100 + i));
      e.is_cmp = 1; e.vec = mk_word(tag, 100 + i); e.id = i; e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Source FIFO model: presents head word, pops when the DUT asserted o_Read before the edge.
  initial begin
    bus.i_Valid  = 1'b0;
    bus.i_Vector = '0;
    bus.i_Ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
      bus.i_Vector = (src_q.size() > 0) ? src_q[0] : '0;
      bus.i_Valid  = (src_q.size() > 0) && !(gap_mode && (gap_ctr % 3 == 2));
      gap_ctr++;
      bus.i_Ready  = toggle_mode ? ~bus.i_Ready : 1'b1;
      #1;
      pop_pending = bus.o_Read && !rst;
    end
  end

  // Monitor: compares every strobe against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_CmpVectorNoWack) wack_cnt++;
      if (bus.o_Done) done_cnt++;
      if (bus.o_RefLoad != '0 || bus.o_CmpValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {bus.o_CmpValid, bus.o_RefLoad}, 0);
        end else begin
          e = exp_q.pop_front();
          chk(e.is_cmp ? "cmp_valid" : "ref_cmpvalid", bus.o_CmpValid, e.is_cmp);
          chk("refload", bus.o_RefLoad, e.is_cmp ? 0 : (1 << e.id));
          chk("vector", bus.o_Vector, e.vec);
          chk("vec_id", bus.o_VecID, e.id);
          chk("cmp_last", bus.o_CmpLast, e.last);
        end
        if (bus.o_CmpValid) cmp_seen++;
        else                ref_seen++;
      end
    end
  end

  task automatic config_write(input int v, input bit exp_ack);
    bus.i_CmpVectorNo      = v[IW-1:0];
    bus.i_CmpVectorNoValid = 1'b1;
    step();
    bus.i_CmpVectorNoValid = 1'b0;
    if (exp_ack) exp_wacks++;
    chk("wack", bus.o_CmpVectorNoWack, exp_ack);
    step();
    chk("wack_one_cycle", bus.o_CmpVectorNoWack, 0);
  endtask

  task automatic finish_round(input string name);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      step();
      if (done_cnt != d0) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) exp_rounds++;
    step();
    chk({name, "_one_done"}, done_cnt - d0, 1);
    chk({name, "_busy_after"}, bus.o_Busy, 0);
    chk({name, "_drained"}, exp_q.size(), 0);
`ifdef SCHED_ROUND_CNT_EN
    chk({name, "_roundcnt"}, bus.o_RoundCnt, exp_rounds);
`else
    chk({name, "_roundcnt"}, bus.o_RoundCnt, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d0;
    bit seen;
    rst = 1'b1;
    bus.i_CmpVectorNo      = '0;
    bus.i_CmpVectorNoValid = 1'b0;
    repeat (3) step();
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_done", bus.o_Done, 0);
    chk("rst_read", bus.o_Read, 0);
    chk("rst_wack", bus.o_CmpVectorNoWack, 0);
    chk("rst_refload", bus.o_RefLoad, 0);
    chk("rst_cmpvalid", {bus.o_CmpValid, bus.o_CmpLast}, 0);
    chk("rst_vector", bus.o_Vector, 0);
    chk("rst_vecid", bus.o_VecID, 0);
    chk("rst_roundcnt", bus.o_RoundCnt, 0);
    rst = 1'b0;
    step();

    // Basic round: count 4, 12 words queued, ready always high.
    load_round(4, 1);
    config_write(4, 1);
    chk("r1_busy", bus.o_Busy, 1);
    finish_round("r1");

    // Count 0 with words waiting: ack only, no round, no pops.
    load_round(3, 3);
    config_write(0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zero_read", bus.o_Read, 0);
      chk("zero_busy", bus.o_Busy, 0);
    end

    // Config write during streaming is ignored.
    toggle_mode = 1;
    config_write(3, 1);
    c0 = cmp_seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (cmp_seen != c0) seen = 1;
    end
    chk("r3_stream_reached", seen, 1);
    config_write(9, 0);
    finish_round("r3");
    chk("wack_count", wack_cnt, exp_wacks);

    // Toggling ready plus valid gaps, count 6.
    gap_mode = 1;
    load_round(6, 4);
    config_write(6, 1);
    finish_round("r4");
    toggle_mode = 0;
    gap_mode = 0;

    // Reset after three reference loads abandons the round.
    load_round(4, 5);
    config_write(4, 1);
    c0 = ref_seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (ref_seen - c0 >= 3) seen = 1;
      else step();
    end
    chk("r5_three_refs", seen, 1);
    d0 = done_cnt;
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    pop_pending = 0;
    #1;
    chk("midrst_vector", bus.o_Vector, 0);
    chk("midrst_refload", bus.o_RefLoad, 0);
    chk("midrst_busy", bus.o_Busy, 0);
    chk("midrst_read", bus.o_Read, 0);
    chk("midrst_vecid", bus.o_VecID, 0);
    exp_rounds = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_roundcnt", bus.o_RoundCnt, 0);
    load_round(2, 6);
    config_write(2, 1);
    finish_round("r6");

    // Back-to-back rounds and the maximum count.
    load_round(1, 7);
    config_write(1, 1);
    finish_round("r7");
    load_round(2, 8);
    config_write(2, 1);
    finish_round("r8");
    load_round(3, 9);
    config_write(3, 1);
    finish_round("r9");
    load_round(255, 10);
    config_write(255, 1);
    finish_round("r10");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
